// File: rtl/bitserial_alu_sequencer.sv
// bitserial_alu_sequencer: drives an external 1-bit ALU slice LSB first, one bit per clock,
// and assembles the WIDTH-bit result plus carry/overflow/zero flags.
module bitserial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_ctl1,
  output logic             slice_ctl2,
  input  logic             slice_and,
  input  logic             slice_nand,
  input  logic             slice_or,
  input  logic             slice_nor,
  input  logic             slice_xor,
  input  logic             slice_sum,
  input  logic             slice_cout
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_SLT = 3'd3,
                         OP_AND = 3'd4, OP_NAND = 3'd5, OP_NOR = 3'd6;
  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_cin_msb, r_cout, r_sum_msb, r_done;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_result;
  logic             r_carryout, r_overflow, r_zero;
  logic             w_run, w_arith, w_inv, w_last, w_bit, w_ovf, w_ready, w_start_inv;
  logic [WIDTH-1:0] w_fin_res;
  assign w_run       = r_state == S_RUN;
  assign w_arith     = r_op == OP_ADD || r_op == OP_SUB || r_op == OP_SLT;
  assign w_inv       = r_op == OP_SUB || r_op == OP_SLT;
  assign w_last      = r_idx == IW'(WIDTH - 1);
  assign w_start_inv = op == OP_SUB || op == OP_SLT;
  // ready is masked during the done cycle so a start there is never taken
  assign w_ready     = r_state == S_IDLE && !r_done;
  assign w_bit = w_arith      ? slice_sum  :
                 r_op == OP_XOR  ? slice_xor  :
                 r_op == OP_AND  ? slice_and  :
                 r_op == OP_NAND ? slice_nand :
                 r_op == OP_NOR  ? slice_nor  : slice_or;
  assign w_ovf     = w_arith & (r_cin_msb ^ r_cout);
  assign w_fin_res = r_op == OP_SLT ? {{(WIDTH-1){1'b0}}, r_sum_msb ^ w_ovf} : r_res;
  assign slice_a    = w_run & r_a[r_idx];
  assign slice_b    = w_run & r_b[r_idx];
  assign slice_cin  = w_run & r_carry;
  assign slice_ctl1 = w_run & w_arith;
  assign slice_ctl2 = w_run & w_inv;
  assign ready    = w_ready;
  assign done     = r_done;
  assign result   = r_result;
  assign carryout = r_carryout;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_cin_msb  <= 1'b0;
      r_cout     <= 1'b0;
      r_sum_msb  <= 1'b0;
      r_done     <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start && w_ready) begin
          r_a     <= operand_a;
          r_b     <= operand_b;
          r_op    <= op;
          r_idx   <= '0;
          r_carry <= w_start_inv;
          r_state <= S_RUN;
        end
      end else if (r_state == S_RUN) begin
        r_res[r_idx] <= w_bit;
        r_carry      <= w_arith & slice_cout;
        if (w_last) begin
          r_cin_msb <= r_carry;
          r_cout    <= slice_cout;
          r_sum_msb <= slice_sum;
          r_state   <= S_FIN;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end else begin
        r_result   <= w_fin_res;
        r_carryout <= w_arith & r_cout;
        r_overflow <= w_ovf;
        r_zero     <= ~|w_fin_res;
        r_done     <= 1'b1;
        r_state    <= S_IDLE;
      end
    end
  end
endmodule
